// File: rtl/async_fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_arb_pkg
// Shared types and defaults for the async FIFO write-side arbiter.
//   arb_state_t    : arbiter mode (IDLE = round-robin, BURST = locked owner)
//   NREQ_DEF       : default number of write requesters
//   BURST_MAX_DEF  : default maximum words per locked burst
//   wrap_inc()     : index + 1 modulo n
// `ASIZE (write data width) falls back to 8 when not supplied by the build.
// ---------------------------------------------------------------------------
`ifndef ASIZE
`define ASIZE 8
`endif

package async_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned NREQ_DEF      = 4;
    localparam int unsigned BURST_MAX_DEF = 8;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/async_fifo_wr_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: finds the first asserted request at or
// after ptr, wrapping from NREQ-1 back to 0.
//   req     in  NREQ  request vector
//   ptr     in  PW    search start index
//   win_oh  out NREQ  one-hot winner (all zero when nothing requests)
//   win_idx out PW    winner index (0 when nothing requests)
//   valid   out 1     at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import async_fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    localparam int unsigned PW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx,
    output logic            valid
);

    logic [PW-1:0] cand;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        valid   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PW'((32'(ptr) + k) % NREQ);
            if (!valid && req[cand]) begin
                valid         = 1'b1;
                win_idx       = cand;
                win_oh[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_arb
// Write-side arbiter in front of an async FIFO. Requesters are served
// round-robin one word at a time; a requester holding lock gets exclusive
// ownership for up to BURST_MAX consecutive accepted words.
// Grants are combinational (zero-cycle) from req/wfull and registered state.
//
// Ports
//   wclk      in  1            write-domain clock
//   wrst      in  1            asynchronous active-low reset
//   req       in  NREQ         per-requester write request
//   lock      in  NREQ         burst ownership request, sampled with req
//   data      in  NREQ*ASIZE   requester i data in slice i
//   wfull     in  1            FIFO full flag
//   gnt       out NREQ         one-hot accept, word taken this cycle
//   winc      out 1            FIFO write strobe (|gnt)
//   wdata     out ASIZE        granted data, 0 when winc=0
//   owner     out PW           current/last granted index
//   busy      out 1            high while in BURST
//   word_cnt  out 32           accepted words, saturating   (stats build)
//   stall_cnt out 16           cycles with |req && wfull    (stats build)
//
// Optional feature macro: ASYNC_FIFO_WR_ARB_STATS_EN adds word_cnt/stall_cnt.
// ---------------------------------------------------------------------------
module async_fifo_wr_arb
    import async_fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF,
    localparam int unsigned PW       = $clog2(NREQ)
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*`ASIZE-1:0]  data,
    input  logic                    wfull,
    output logic [NREQ-1:0]         gnt,
    output logic                    winc,
    output logic [`ASIZE-1:0]       wdata,
    output logic [PW-1:0]           owner,
    output logic                    busy
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    ,
    output logic [31:0]             word_cnt,
    output logic [15:0]             stall_cnt
`endif
);

    localparam logic [7:0] BMAX     = 8'(BURST_MAX);
    localparam bit         LOCKABLE = (BURST_MAX > 1);

    arb_state_t      state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [7:0]      beat, beat_n;
    logic [PW-1:0]   owner_n;

    logic [NREQ-1:0] pick_oh;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .valid   (pick_valid)
    );

    // State register
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state <= IDLE;
            ptr   <= '0;
            beat  <= '0;
            owner <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            beat  <= beat_n;
            owner <= owner_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        beat_n  = beat;
        owner_n = owner;
        unique case (state)
            IDLE: begin
                if (!wfull && pick_valid) begin
                    owner_n = pick_idx;
                    if (lock[pick_idx] && LOCKABLE) begin
                        state_n = BURST;
                        beat_n  = 8'd1;
                    end else begin
                        ptr_n = PW'(wrap_inc(32'(pick_idx), NREQ));
                    end
                end
            end
            BURST: begin
                // A dropped request ends the burst even while the FIFO is full;
                // a full FIFO otherwise freezes beat so stalls never count.
                if (!req[owner]) begin
                    state_n = IDLE;
                    ptr_n   = PW'(wrap_inc(32'(owner), NREQ));
                    beat_n  = '0;
                end else if (!wfull) begin
                    beat_n = beat + 8'd1;
                    if (!lock[owner] || (beat_n == BMAX)) begin
                        state_n = IDLE;
                        ptr_n   = PW'(wrap_inc(32'(owner), NREQ));
                        beat_n  = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output logic; wrst gates the grant so reset silences the FIFO port at once
    always_comb begin
        gnt = '0;
        if (wrst && !wfull) begin
            unique case (state)
                IDLE:    gnt = pick_oh;
                BURST:   gnt[owner] = req[owner];
                default: gnt = '0;
            endcase
        end
        winc  = |gnt;
        wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            wdata = wdata | (data[i*`ASIZE +: `ASIZE] & {`ASIZE{gnt[i]}});
        end
        busy = (state == BURST);
    end

`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (winc && (word_cnt != '1)) begin
                word_cnt <= word_cnt + 32'd1;
            end
            if ((|req) && wfull && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_async_fifo_wr_arb
// Directed scenarios followed by randomized traffic, each cycle compared
// against a behavioural arbitration model kept in this bench.
// ---------------------------------------------------------------------------
`ifndef ASIZE
`define ASIZE 8
`endif

module tb_async_fifo_wr_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned BM = 8;
    localparam int unsigned W  = `ASIZE;
    localparam int unsigned PW = 2;

    logic           wclk = 1'b0;
    logic           wrst;
    logic [N-1:0]   req, lock, gnt;
    logic [N*W-1:0] data;
    logic           wfull, winc, busy;
    logic [W-1:0]   wdata;
    logic [PW-1:0]  owner;
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    logic [31:0]    word_cnt;
    logic [15:0]    stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int unsigned m_ptr, m_owner, m_cnt, m_words, m_stalls;
    bit          m_burst;

    // Outputs captured by the most recent step
    logic [N-1:0]  obs_gnt;
    logic          obs_busy, obs_winc;
    logic [PW-1:0] obs_owner;

    async_fifo_wr_arb #(
        .NREQ      (N),
        .BURST_MAX (BM)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req       (req),
        .lock      (lock),
        .data      (data),
        .wfull     (wfull),
        .gnt       (gnt),
        .winc      (winc),
        .wdata     (wdata),
        .owner     (owner),
        .busy      (busy)
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 wclk = ~wclk;

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_burst = 0;
        m_words = 0; m_stalls = 0;
    endtask

    // Drive one cycle (called just after a rising edge), check at the falling
    // edge, then advance the model and move to just after the next rising edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
        logic [N-1:0]  eg;
        logic [W-1:0]  ed;
        logic [PW-1:0] ix;
        int unsigned   w;
        bit            hit;
        req = r; lock = l; wfull = f;
        for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
        @(negedge wclk);
        eg = '0; ed = '0; hit = 0; w = 0;
        if (!f) begin
            if (m_burst) begin
                ix = PW'(m_owner);
                if (r[ix]) begin hit = 1; w = m_owner; end
            end else begin
                for (int unsigned k = 0; k < N; k++) begin
                    ix = PW'((m_ptr + k) % N);
                    if (!hit && r[ix]) begin hit = 1; w = (m_ptr + k) % N; end
                end
            end
        end
        if (hit) begin
            ix     = PW'(w);
            eg[ix] = 1'b1;
            ed     = W'(data >> (w * W));
        end
        chk("gnt",   32'(gnt),   32'(eg));
        chk("winc",  32'(winc),  32'(hit));
        chk("wdata", 32'(wdata), 32'(ed));
        chk("busy",  32'(busy),  32'(m_burst));
        chk("owner", 32'(owner), m_owner);
        obs_gnt = gnt; obs_busy = busy; obs_winc = winc; obs_owner = owner;

        if (hit) m_words++;
        if (f && (|r)) m_stalls++;

        ix = PW'(m_owner);
        if (m_burst) begin
            if (!r[ix]) begin
                m_burst = 0; m_ptr = (m_owner + 1) % N;
            end else if (hit) begin
                m_cnt++;
                if (!l[ix] || m_cnt == BM) begin
                    m_burst = 0; m_ptr = (m_owner + 1) % N;
                end
            end
        end else if (hit) begin
            m_owner = w;
            ix = PW'(w);
            if (l[ix] && BM > 1) begin
                m_burst = 1; m_cnt = 1;
            end else begin
                m_ptr = (w + 1) % N;
            end
        end
        @(posedge wclk);
        #1;
    endtask

    initial begin
        wrst = 1'b0; req = '1; lock = '0; wfull = 1'b0; data = '1;
        model_reset();
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        chk("rst_gnt",   32'(gnt),   32'd0);
        chk("rst_winc",  32'(winc),  32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        @(posedge wclk);
        #1 wrst = 1'b1;

        // Plain round robin from ptr=0
        step(4'b1010, 4'b0000, 1'b0);
        chk("rr_first",  32'(obs_gnt), 32'h2);
        step(4'b1010, 4'b0000, 1'b0);
        chk("rr_second", 32'(obs_gnt), 32'h8);
        step(4'b1111, 4'b0000, 1'b0);
        chk("rr_wrap",   32'(obs_gnt), 32'h1);

        // Locked burst capped at BURST_MAX while another requester waits
        for (int i = 0; i < BM; i++) begin
            step(4'b0101, 4'b0100, 1'b0);
            chk("burst_gnt",  32'(obs_gnt),  32'h4);
            chk("burst_busy", 32'(obs_busy), (i > 0) ? 32'd1 : 32'd0);
        end
        step(4'b0101, 4'b0100, 1'b0);
        chk("burst_next", 32'(obs_gnt),  32'h1);
        chk("burst_exit", 32'(obs_busy), 32'd0);

        // FIFO-full stall in the middle of a burst
        repeat (3) step(4'b1000, 4'b1000, 1'b0);
        repeat (3) begin
            step(4'b1000, 4'b1000, 1'b1);
            chk("stall_winc",  32'(obs_winc),  32'd0);
            chk("stall_busy",  32'(obs_busy),  32'd1);
            chk("stall_owner", 32'(obs_owner), 32'd3);
        end
        repeat (5) begin
            step(4'b1000, 4'b1000, 1'b0);
            chk("resume_gnt",  32'(obs_gnt),  32'h8);
            chk("resume_busy", 32'(obs_busy), 32'd1);
        end
        step(4'b0000, 4'b0000, 1'b0);
        chk("resume_done", 32'(obs_busy), 32'd0);

        // Asynchronous reset in the middle of a burst
        repeat (5) step(4'b0010, 4'b0010, 1'b0);
        #2;
        chk("pre_rst_gnt",  32'(gnt),  32'h2);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        wrst = 1'b0;
        #1;
        chk("mid_rst_gnt",   32'(gnt),   32'd0);
        chk("mid_rst_winc",  32'(winc),  32'd0);
        chk("mid_rst_wdata", 32'(wdata), 32'd0);
        chk("mid_rst_busy",  32'(busy),  32'd0);
        chk("mid_rst_owner", 32'(owner), 32'd0);
        model_reset();
        @(posedge wclk);
        #1 wrst = 1'b1;
        step(4'b1111, 4'b0000, 1'b0);
        chk("post_rst_gnt", 32'(obs_gnt), 32'h1);

        // Owner drops its request inside a burst
        step(4'b0010, 4'b0010, 1'b0);
        step(4'b0010, 4'b0010, 1'b0);
        step(4'b0101, 4'b0010, 1'b0);
        chk("drop_gnt",  32'(obs_gnt),  32'd0);
        chk("drop_busy", 32'(obs_busy), 32'd1);
        step(4'b1111, 4'b0000, 1'b0);
        chk("drop_ptr",  32'(obs_gnt),  32'h4);
        chk("drop_idle", 32'(obs_busy), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(N'($urandom), N'($urandom) & N'($urandom), ($urandom_range(0, 3) == 0));
        end

`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
        chk("stats_words",  word_cnt,       m_words);
        chk("stats_stalls", 32'(stall_cnt), m_stalls);

        wrst = 1'b0;
        model_reset();
        @(posedge wclk);
        #1 wrst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step(4'b0001, 4'b0000, (i % 5) == 3);
        end
        chk("stats_words_20", word_cnt,       32'd20);
        chk("stats_stalls_5", 32'(stall_cnt), 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/async_fifo_wr_arb.md
ASYNC_FIFO_WR_ARB -- requirements
Module: async_fifo_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter BURST_MAX, default 8, max words per locked burst (1..255).
REQ-003 SHALL use the `ASIZE define as the data width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port: wclk  in  1  write-domain clock; all state on rising edge.
REQ-006 SHALL have port: wrst  in  1  async active-low reset.
REQ-007 SHALL have port: req  in  NREQ  per-requester write request, held until gnt.
REQ-008 SHALL have port: lock  in  NREQ  request burst ownership, sampled with req.
REQ-009 SHALL have port: data  in  NREQ*`ASIZE  requester i data in slice i.
REQ-010 SHALL have port: wfull  in  1  FIFO full flag.
REQ-011 SHALL have port: gnt  out  NREQ  one-hot accept; word taken this cycle.
REQ-012 SHALL have port: winc  out  1  FIFO write strobe, equals |gnt.
REQ-013 SHALL have port: wdata  out  `ASIZE  granted requester's data; 0 when winc=0.
REQ-014 SHALL have port: owner  out  $clog2(NREQ)  current/last granted index.
REQ-015 SHALL have port: busy  out  1  high while in BURST.

Function
REQ-016 SHALL drive gnt/winc/wdata combinationally from req, wfull and registered state; zero-cycle latency.
REQ-017 SHALL never assert winc while wfull=1; no gnt that cycle, state and pointer hold.
REQ-018 SHALL implement states IDLE and BURST.
REQ-019 SHALL, in IDLE with wfull=0 and |req, grant the first requesting index at or after ptr (wrapping NREQ-1 -> 0).
REQ-020 SHALL, in IDLE on a grant with lock[w]=0 or BURST_MAX=1, set ptr <= w+1 mod NREQ, stay IDLE.
REQ-021 SHALL, in IDLE on a grant with lock[w]=1 and BURST_MAX>1, enter BURST, owner <= w, beat <= 1, ptr unchanged.
REQ-022 SHALL, in BURST, grant only owner, when req[owner]=1 and wfull=0; other requesters get no gnt.
REQ-023 SHALL exit BURST to IDLE, ptr <= owner+1, when: accepted word with lock[owner]=0; or beat reaches BURST_MAX on an accepted word; or req[owner]=0.
REQ-024 SHALL increment beat by 1 per accepted BURST word; wfull stalls do not count.
REQ-025 SHALL update owner on every grant.

Reset
REQ-026 SHALL, while wrst=0, force state=IDLE, ptr=0, beat=0, owner=0, busy=0, gnt=0, winc=0, wdata=0, immediately and asynchronously, including mid-burst.
REQ-027 SHALL resume arbitration from ptr=0 on the first rising edge after wrst deasserts.

Configuration
REQ-028 SHALL, with macro ASYNC_FIFO_WR_ARB_STATS_EN defined, add outputs word_cnt (32b, accepted words) and stall_cnt (16b, cycles with |req=1 and wfull=1), both saturating, reset to 0.
REQ-029 SHALL, without ASYNC_FIFO_WR_ARB_STATS_EN, omit both ports and counters entirely.

Structure
REQ-030 SHALL place the state enum (IDLE, BURST) and default NREQ/BURST_MAX constants in package async_fifo_arb_pkg.
REQ-031 SHALL use one sub-module rr_pick: combinational round-robin picker (req, ptr -> one-hot winner, index, valid).

Verification
REQ-032 SHALL cover: req=4'b1010, ptr=0, wfull=0 -> gnt=4'b0010, then gnt=4'b1000 next cycle, ptr=0 after.
REQ-033 SHALL cover: req[2] with lock[2]=1 for 10 words, BURST_MAX=8, req[0] also high -> 8 consecutive gnt[2], busy=1, then gnt[0].
REQ-034 SHALL cover: wfull=1 for 3 cycles mid-burst (beat=3) -> winc=0, beat stays 3, owner unchanged, burst resumes after.
REQ-035 SHALL cover: wrst=0 asserted at beat=5 -> gnt, winc, busy drop at once; after release req=4'b1111 grants index 0.
REQ-036 SHALL cover: req[1] drops in BURST (owner=1) -> exit to IDLE same edge, ptr=2, no gnt[1].
REQ-037 SHALL cover (STATS_EN): 20 accepted words, 5 full-stall cycles -> word_cnt=20, stall_cnt=5.
